link_credit_scheduler: RTL and testbench
========================================

LINK_CREDIT_SCHEDULER -- requirements
Module: link_credit_scheduler

Interface
REQ-001 SHALL have parameter FLIT_W, default 128, flit width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter NUM_LINKS, default 2, number of physical links (2..4).
REQ-004 SHALL have parameter MAX_CREDITS, default 4, credits per link (1..15); CW = clog2(MAX_CREDITS+1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port req_flit, input, NUM_REQ*FLIT_W, flit of requester i at bits [i*FLIT_W +: FLIT_W].
REQ-008 SHALL have port req_valid, input, NUM_REQ, per-requester flit valid.
REQ-009 SHALL have port req_last, input, NUM_REQ, marks the final flit of a packet.
REQ-010 SHALL have port req_ready, output, NUM_REQ, per-requester accept; at most one bit high.
REQ-011 SHALL have port link_flit, output, NUM_LINKS*FLIT_W, registered flit per link.
REQ-012 SHALL have port link_valid, output, NUM_LINKS, registered one-cycle flit strobe per link.
REQ-013 SHALL have port link_credit, input, NUM_LINKS, one-cycle credit-return pulse per link.
REQ-014 SHALL have port credit_cnt, output, NUM_LINKS*CW, current credit count per link.
REQ-015 SHALL have port credit_err, output, 1, sticky flag: credit returned to a full counter.

Function
REQ-016 SHALL implement FSM states IDLE and LOCKED, with owner register (clog2(NUM_REQ) bits), rr_ptr and stripe_ptr.
REQ-017 In IDLE, SHALL select the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ; it SHALL register owner=i and enter LOCKED the next cycle; req_ready SHALL be all-zero in IDLE.
REQ-018 IDLE with no req_valid SHALL remain IDLE with no state change.
REQ-019 In LOCKED, sel_link SHALL be the first link at or after stripe_ptr, modulo NUM_LINKS, with credit_cnt>0.
REQ-020 In LOCKED, req_ready[owner] SHALL be 1 iff some link has credit_cnt>0 (combinational); every other req_ready bit SHALL be 0.
REQ-021 A flit is accepted when req_valid[owner]&req_ready[owner] are both high in cycle N.
REQ-022 On acceptance, link_flit[sel_link] SHALL capture the flit, and link_valid[sel_link] SHALL be 1 in cycle N+1 only (latency 1).
REQ-023 On acceptance, credit_cnt[sel_link] SHALL decrement by 1 and stripe_ptr SHALL become (sel_link+1) mod NUM_LINKS.
REQ-024 A link with zero credits SHALL be skipped without stalling; when all links have zero credits, the FSM SHALL hold LOCKED with req_ready=0.
REQ-025 Acceptance with req_last=1 SHALL return the FSM to IDLE and set rr_ptr=(owner+1) mod NUM_REQ; packets SHALL never interleave between requesters.
REQ-026 Each packet incurs exactly one arbitration bubble cycle (the IDLE cycle).
REQ-027 A link_credit pulse SHALL increment that link's credit_cnt by 1 in the next cycle.
REQ-028 A simultaneous decrement and return on the same link SHALL leave the count unchanged.
REQ-029 A return at credit_cnt=MAX_CREDITS with no decrement SHALL saturate the count and set credit_err=1 until reset.
REQ-030 link_flit SHALL hold its last value when not written; link_valid SHALL be 0 in every cycle without a new flit.

Reset
REQ-031 While rst=1 at posedge clk, the block SHALL reset: FSM=IDLE, owner=0, rr_ptr=0, stripe_ptr=0, credit_cnt=MAX_CREDITS on every link, link_valid=0, link_flit=0, credit_err=0.
REQ-032 Reset asserted mid-packet SHALL abort the packet with no further link_valid; link_credit pulses during reset SHALL be ignored.
REQ-033 req_ready SHALL be 0 during reset and in the first cycle after it.

Verification
REQ-034 Single requester: req0 sends a 4-flit packet, credits 4/4 -> flits appear on link0, link1, link0, link1 at acceptance+1; credit_cnt=2/2; FSM returns to IDLE.
REQ-035 Fairness: req0..3 held valid with 2-flit packets -> grant order 0,1,2,3,0; no interleaving; one bubble per packet.
REQ-036 Credit skip: link0 credit=0, link1=4, stripe_ptr=0 -> flit goes to link1; if no link has credit, req_ready=0 until a link_credit pulse, then acceptance resumes the next cycle.
REQ-037 Simultaneous events: send on link0 and pulse link0_credit in the same cycle at count 3 -> count stays 3; pulse credit at count 4 with no send -> count 4 and credit_err=1.
REQ-038 Reset asserted mid-packet at flit 2 of 4 -> next cycle link_valid=0, credits=4/4, FSM IDLE; a new packet arbitrates from rr_ptr=0.

Source files
------------

// File: rtl/link_credit_scheduler.sv
// Credit-based packet scheduler: one requester owns the links per packet,
// flits stripe round-robin across links that still hold credit.
module link_credit_scheduler #(
   parameter int FLIT_W      = 128,
   parameter int NUM_REQ     = 4,
   parameter int NUM_LINKS   = 2,
   parameter int MAX_CREDITS = 4,
   localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ*FLIT_W-1:0]   req_flit,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_LINKS*FLIT_W-1:0] link_flit,
   output logic [NUM_LINKS-1:0]        link_valid,
   input  logic [NUM_LINKS-1:0]        link_credit,
   output logic [NUM_LINKS*CW-1:0]     credit_cnt,
   output logic                        credit_err
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int LW = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                  state_q, state_d;
   logic [OW-1:0]           owner_q, owner_d;
   logic [OW-1:0]           rr_q, rr_d;
   logic [LW-1:0]           stripe_q, stripe_d;
   logic [CW-1:0]           cnt_q [NUM_LINKS];
   logic [CW-1:0]           cnt_d [NUM_LINKS];
   logic [NUM_LINKS-1:0]    lv_q, lv_d;
   logic [NUM_LINKS*FLIT_W-1:0] lf_q, lf_d;
   logic                    err_q, err_d;

   logic [NUM_LINKS-1:0]    has_cr;
   logic                    any_cr;
   logic                    sel_found;
   logic [LW-1:0]           sel;
   logic                    grant_found;
   logic [OW-1:0]           grant_idx;
   logic                    accept;
   logic                    owner_valid;
   logic                    owner_last;
   logic [FLIT_W-1:0]       owner_flit;

   always_comb begin
      has_cr = '0;
      for (int l = 0; l < NUM_LINKS; l++) begin
         has_cr[l] = (cnt_q[l] != '0);
      end
      any_cr = |has_cr;
   end

   // First link with credit, starting at the stripe pointer
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      for (int k = 0; k < NUM_LINKS; k++) begin
         if (!sel_found && has_cr[(int'(stripe_q) + k) % NUM_LINKS]) begin
            sel_found = 1'b1;
            sel       = LW'((int'(stripe_q) + k) % NUM_LINKS);
         end
      end
   end

   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = OW'((int'(rr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      owner_valid = req_valid[owner_q];
      owner_last  = req_last[owner_q];
      owner_flit  = req_flit[int'(owner_q)*FLIT_W +: FLIT_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_found) state_d = LOCKED;
         LOCKED:  if (accept && owner_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (state_q == LOCKED && any_cr && !rst) begin
         req_ready[owner_q] = 1'b1;
      end
      accept = req_ready[owner_q] & owner_valid;
   end

   always_comb begin
      owner_d  = owner_q;
      rr_d     = rr_q;
      stripe_d = stripe_q;
      lv_d     = '0;
      lf_d     = lf_q;
      err_d    = err_q;
      if (state_q == IDLE && grant_found) begin
         owner_d = grant_idx;
      end
      if (accept) begin
         stripe_d = LW'((int'(sel) + 1) % NUM_LINKS);
         lv_d[sel] = 1'b1;
         lf_d[int'(sel)*FLIT_W +: FLIT_W] = owner_flit;
         if (owner_last) begin
            rr_d = OW'((int'(owner_q) + 1) % NUM_REQ);
         end
      end
      // A return and a send on the same link cancel out
      for (int l = 0; l < NUM_LINKS; l++) begin
         cnt_d[l] = cnt_q[l];
         if (link_credit[l] && !(accept && sel == LW'(l))) begin
            if (cnt_q[l] == CW'(MAX_CREDITS)) begin
               err_d = 1'b1;
            end else begin
               cnt_d[l] = cnt_q[l] + CW'(1);
            end
         end else if (!link_credit[l] && accept && sel == LW'(l)) begin
            cnt_d[l] = cnt_q[l] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q  <= '0;
         rr_q     <= '0;
         stripe_q <= '0;
         lv_q     <= '0;
         lf_q     <= '0;
         err_q    <= 1'b0;
         for (int l = 0; l < NUM_LINKS; l++) begin
            cnt_q[l] <= CW'(MAX_CREDITS);
         end
      end else begin
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         stripe_q <= stripe_d;
         lv_q     <= lv_d;
         lf_q     <= lf_d;
         err_q    <= err_d;
         for (int l = 0; l < NUM_LINKS; l++) begin
            cnt_q[l] <= cnt_d[l];
         end
      end
   end

   always_comb begin
      credit_cnt = '0;
      for (int l = 0; l < NUM_LINKS; l++) begin
         credit_cnt[l*CW +: CW] = cnt_q[l];
      end
   end

   assign link_valid = lv_q;
   assign link_flit  = lf_q;
   assign credit_err = err_q;

endmodule

// File: tb/tb_link_credit_scheduler.sv
// Scoreboard bench for link_credit_scheduler: a reference model
// predicts each cycle, accepted flits are queued and matched on output.
module tb_link_credit_scheduler;

  localparam int FW = 128;
  localparam int NR = 4;
  localparam int NL = 2;
  localparam int MC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NR*FW-1:0] req_flit;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [NL*FW-1:0] link_flit;
  logic [NL-1:0] link_valid;
  logic [NL-1:0] link_credit;
  logic [NL*CW-1:0] credit_cnt;
  logic credit_err;

  always #5 clk = ~clk;

  link_credit_scheduler #(
    .FLIT_W(FW),
    .NUM_REQ(NR),
    .NUM_LINKS(NL),
    .MAX_CREDITS(MC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_flit(req_flit),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .link_flit(link_flit),
    .link_valid(link_valid),
    .link_credit(link_credit),
    .credit_cnt(credit_cnt),
    .credit_err(credit_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int link;
    logic [FW-1:0] flit;
  } exp_t;

  exp_t sbq[$];

  bit m_lock;
  int m_owner, m_rr, m_stripe;
  int m_cnt[NL];
  bit m_err;
  logic [FW-1:0] m_flit[NL];

  int s_len[NR], s_pkts[NR], s_idx[NR], s_seq[NR];

  bit auto_ret = 0;
  logic [NL-1:0] auto_mask = '0;

  int obs_req[$];
  int obs_link[$];
  int obs_cyc[$];
  int cyc = 0;

  function automatic logic [FW-1:0] flit_of(int i, int s, int x);
    logic [FW-1:0] f;
    f = '0;
    f[31:24] = i[7:0];
    f[23:16] = s[7:0];
    f[15:0] = x[15:0];
    f[FW-1 -: 32] = 32'h5A5A_0000 + 32'(x * 7 + s);
    return f;
  endfunction

  task automatic mreset();
    m_lock = 0;
    m_owner = 0;
    m_rr = 0;
    m_stripe = 0;
    m_err = 0;
    for (int l = 0; l < NL; l++) begin
      m_cnt[l] = MC;
      m_flit[l] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      s_pkts[i] = 0;
      s_idx[i] = 0;
    end
    sbq.delete();
    auto_mask = '0;
  endtask

  task automatic step(input logic [NL-1:0] cred, input bit do_rst);
    logic [NR-1:0] exp_ready;
    logic [NL-1:0] cr_in;
    logic [FW-1:0] f;
    int sel, dl;
    bit acc, lst, dec, inc;
    exp_t e;
    rst = do_rst;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = s_pkts[i] > 0;
      req_last[i] = (s_pkts[i] > 0) && (s_idx[i] == s_len[i] - 1);
      req_flit[i*FW +: FW] = flit_of(i, s_seq[i], s_idx[i]);
    end
    cr_in = cred | (auto_ret ? auto_mask : '0);
    link_credit = cr_in;
    auto_mask = '0;
    #1;
    sel = -1;
    for (int k = 0; k < NL; k++) begin
      if (sel < 0 && m_cnt[(m_stripe + k) % NL] > 0)
        sel = (m_stripe + k) % NL;
    end
    exp_ready = '0;
    if (!do_rst && m_lock && sel >= 0) exp_ready[m_owner] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    acc = exp_ready[m_owner] && req_valid[m_owner];
    if (do_rst) begin
      mreset();
    end else begin
      if (acc) begin
        f = req_flit[m_owner*FW +: FW];
        lst = req_last[m_owner];
        sbq.push_back('{sel, f});
        m_flit[sel] = f;
        m_stripe = (sel + 1) % NL;
        auto_mask[sel] = 1'b1;
        if (lst) begin
          s_idx[m_owner] = 0;
          s_pkts[m_owner]--;
          s_seq[m_owner]++;
          m_lock = 0;
          m_rr = (m_owner + 1) % NR;
        end else begin
          s_idx[m_owner]++;
        end
      end else if (!m_lock) begin
        for (int k = 0; k < NR; k++) begin
          if (!m_lock && req_valid[(m_rr + k) % NR]) begin
            m_lock = 1;
            m_owner = (m_rr + k) % NR;
          end
        end
      end
      for (int l = 0; l < NL; l++) begin
        dec = acc && sel == l;
        inc = cr_in[l];
        if (inc && !dec) begin
          if (m_cnt[l] == MC) m_err = 1;
          else m_cnt[l]++;
        end else if (dec && !inc) begin
          m_cnt[l]--;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (|link_valid) begin
      dl = link_valid[1] ? 1 : 0;
      obs_link.push_back(dl);
      obs_req.push_back(int'(link_flit[dl*FW+24 +: 8]));
      obs_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        chk("unexpected_flit", link_valid, '0);
      end else begin
        e = sbq.pop_front();
        chk("link_valid", link_valid, 1 << e.link);
        chk("link_flit", link_flit[e.link*FW +: FW], e.flit);
      end
    end else if (sbq.size() != 0) begin
      chk("missing_flit", link_valid, 1 << sbq[0].link);
      void'(sbq.pop_front());
    end
    for (int l = 0; l < NL; l++) begin
      chk("flit_hold", link_flit[l*FW +: FW], m_flit[l]);
      chk("credit_cnt", credit_cnt[l*CW +: CW], m_cnt[l]);
    end
    chk("credit_err", credit_err, m_err);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    bit busy = 1;
    while (busy && c < budget) begin
      step('0, 0);
      c++;
      busy = m_lock;
      for (int i = 0; i < NR; i++) if (s_pkts[i] > 0) busy = 1;
    end
    chk("drain_budget", c < budget, 1'b1);
  endtask

  task automatic do_reset();
    step('0, 1);
    step('0, 1);
  endtask

  int b, p;

  initial begin
    rst = 1'b1;
    req_flit = '0;
    req_valid = '0;
    req_last = '0;
    link_credit = '0;
    for (int i = 0; i < NR; i++) begin
      s_len[i] = 1;
      s_seq[i] = 0;
    end
    mreset();

    // reset state
    do_reset();
    chk("rst_cnt", credit_cnt, {3'd4, 3'd4});
    chk("rst_valid", link_valid, '0);
    chk("rst_err", credit_err, 1'b0);
    step('0, 0);
    chk("rst_ready_after", req_ready, '0);

    // single requester, 4-flit packet striped 0,1,0,1
    b = obs_link.size();
    s_len[0] = 4;
    s_pkts[0] = 1;
    drain(20);
    for (int k = 0; k < 4; k++) chk("s1_link", obs_link[b+k], k % 2);
    chk("s1_cnt", credit_cnt, {3'd2, 3'd2});
    chk("s1_idle_ready", req_ready, '0);

    // fairness across four requesters
    do_reset();
    auto_ret = 1;
    b = obs_req.size();
    for (int i = 0; i < NR; i++) begin
      s_len[i] = 2;
      s_pkts[i] = (i == 0) ? 2 : 1;
    end
    drain(60);
    auto_ret = 0;
    step('0, 0);
    for (int k = 0; k < 10; k++) begin
      chk("s2_order", obs_req[b+k], (k < 8) ? k / 2 : 0);
      chk("s2_bubble", obs_cyc[b+k] - obs_cyc[b], (k / 2) * 3 + k % 2);
    end

    // credit skip and full starvation
    do_reset();
    s_len[0] = 8;
    s_pkts[0] = 1;
    drain(20);
    chk("s3_empty", credit_cnt, '0);
    repeat (4) step(2'b10, 0);
    b = obs_link.size();
    s_len[0] = 5;
    s_pkts[0] = 1;
    repeat (7) step('0, 0);
    chk("s3_stall", req_ready, '0);
    step(2'b01, 0);
    p = cyc;
    drain(10);
    for (int k = 0; k < 5; k++) chk("s3_link", obs_link[b+k], (k < 4) ? 1 : 0);
    chk("s3_resume", obs_cyc[b+4], p + 1);

    // simultaneous send/return, saturation
    do_reset();
    s_len[0] = 3;
    s_pkts[0] = 1;
    repeat (3) step('0, 0);
    step(2'b01, 0);
    chk("s4_cnt0", credit_cnt[CW-1:0], 3'd3);
    step(2'b10, 0);
    step(2'b10, 0);
    chk("s4_cnt1", credit_cnt[2*CW-1:CW], 3'd4);
    chk("s4_err", credit_err, 1'b1);
    repeat (2) step('0, 0);
    chk("s4_err_sticky", credit_err, 1'b1);

    // reset mid-packet
    do_reset();
    s_len[0] = 1;
    s_pkts[0] = 1;
    drain(10);
    s_len[0] = 4;
    s_pkts[0] = 1;
    repeat (3) step('0, 0);
    step(2'b11, 1);
    chk("s5_valid", link_valid, '0);
    chk("s5_cnt", credit_cnt, {3'd4, 3'd4});
    chk("s5_err", credit_err, 1'b0);
    step('0, 0);
    chk("s5_ready", req_ready, '0);
    b = obs_req.size();
    s_len[0] = 2;
    s_pkts[0] = 1;
    s_len[1] = 2;
    s_pkts[1] = 1;
    drain(20);
    chk("s5_first", obs_req[b], 0);
    chk("s5_second", obs_req[b+2], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
